// File: rtl/bit_index_scanner_if.sv
// Stream bundle for bit_index_scanner: mask word in, one set-bit index out per beat.
// Both sides use valid/ready: a beat transfers on a cycle where valid && ready; valid never drops without a transfer.
interface bit_index_scanner_if #(
  parameter int Width = 32
);
  localparam int IdxWidth = $clog2(Width);

  logic [Width-1:0]    in_data_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [IdxWidth-1:0] out_index_o;
  logic                out_last_o;
  logic                out_valid_o;
  logic                out_ready_i;

  modport master (
    output in_data_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_index_o, out_last_o, out_valid_o
  );

  modport slave (
    input  in_data_i, in_valid_i, out_ready_i,
    output in_ready_o, out_index_o, out_last_o, out_valid_o
  );
endinterface

// File: rtl/bit_index_scanner.sv
// Multi-hot to index stream: emits the index of every set bit of a word, LSB-first.
// Define BIT_INDEX_SCANNER_MSB_FIRST_EN to scan MSB-first instead.
module bit_index_scanner #(
  parameter  int Width    = 32,
  localparam int IdxWidth = $clog2(Width)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  bit_index_scanner_if.slave bus,
  output logic               busy_o,
  output logic               dbg_scan_o
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t              r_state;
  logic [Width-1:0]    r_mask;
  logic [IdxWidth-1:0] w_idx;
  logic [Width-1:0]    w_onehot;
  logic                w_last;

  // Later loop iterations win, so the loop direction picks the priority end.
  always_comb begin
    w_idx    = '0;
    w_onehot = '0;
`ifdef BIT_INDEX_SCANNER_MSB_FIRST_EN
    for (int i = 0; i < Width; i++) begin
`else
    for (int i = Width - 1; i >= 0; i--) begin
`endif
      if (r_mask[i]) begin
        w_idx       = IdxWidth'(i);
        w_onehot    = '0;
        w_onehot[i] = 1'b1;
      end
    end
  end

  assign w_last = (r_mask != '0) && ((r_mask & (r_mask - Width'(1))) == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_mask  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid_i && (bus.in_data_i != '0)) begin
            r_mask  <= bus.in_data_i;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (bus.out_ready_i) begin
            r_mask <= r_mask & ~w_onehot;
            if (w_last) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = (r_state == IDLE);
  assign bus.out_valid_o = (r_state == SCAN);
  assign bus.out_index_o = w_idx;
  assign bus.out_last_o  = w_last;
  assign busy_o          = (r_state == SCAN);
  assign dbg_scan_o      = (r_state == SCAN);

endmodule

// File: tb/tb_bit_index_scanner.sv
// Bench for bit_index_scanner: directed and random words against a queue-based index model.
module tb_bit_index_scanner;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic dbg_scan;

  bit_index_scanner_if #(.Width(W)) bus ();

  bit_index_scanner #(.Width(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus.slave),
    .busy_o     (busy),
    .dbg_scan_o (dbg_scan)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int beats = 0;
  int last_hs_cyc = -100;
  int acc_gap = 0;
  bit rnd_rdy = 1'b0;
  logic [4:0] exp_q[$];
  bit stalled = 1'b0;
  logic [4:0] stall_idx;
  logic stall_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: every set bit of the word, in scan order.
  task automatic model_push(input logic [W-1:0] w);
`ifdef BIT_INDEX_SCANNER_MSB_FIRST_EN
    for (int i = W - 1; i >= 0; i--) if (w[i]) exp_q.push_back(5'(i));
`else
    for (int i = 0; i < W; i++) if (w[i]) exp_q.push_back(5'(i));
`endif
  endtask

  always @(posedge clk) begin
    #1;
    bus.out_ready_i = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Scoreboard / monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      check("in_ready", bus.in_ready_o, exp_q.size() == 0);
      check("out_valid", bus.out_valid_o, exp_q.size() != 0);
      check("busy", busy, exp_q.size() != 0);
      if (stalled) begin
        check("stall_valid", bus.out_valid_o, 1);
        check("stall_idx", bus.out_index_o, stall_idx);
        check("stall_last", bus.out_last_o, stall_last);
      end
      if (bus.out_valid_o && exp_q.size() != 0) begin
        check("index", bus.out_index_o, exp_q[0]);
        check("last", bus.out_last_o, exp_q.size() == 1);
        if (bus.out_ready_i) begin
          void'(exp_q.pop_front());
          beats++;
          if (exp_q.size() == 0) last_hs_cyc = cyc;
        end
      end
      stalled    = bus.out_valid_o && !bus.out_ready_i;
      stall_idx  = bus.out_index_o;
      stall_last = bus.out_last_o;
      if (bus.in_valid_i && bus.in_ready_o) begin
        acc_gap = cyc - last_hs_cyc;
        model_push(bus.in_data_i);
      end
    end
  end

  task automatic send_word(input logic [W-1:0] w, output int waited);
    waited = 0;
    bus.in_data_i  = w;
    bus.in_valid_i = 1'b1;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready_o) break;
      waited++;
      if (waited > 500) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = W'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 || !bus.in_ready_o) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        check("idle_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  int waited;
  int b0;

  initial begin
    bus.in_data_i  = '0;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_index", bus.out_index_o, 0);
    check("rst_last", bus.out_last_o, 0);
    check("rst_valid", bus.out_valid_o, 0);
    check("rst_ready", bus.in_ready_o, 1);
    @(posedge clk); #1;

    b0 = beats;
    send_word(32'd43758, waited);
    check("aaee_accept_wait", waited, 0);
    wait_idle();
    check("aaee_beats", beats - b0, 10);

    b0 = beats;
    send_word(32'd32, waited);
    send_word(32'd4096, waited);
    check("b2b_gap", acc_gap, 1);
    wait_idle();
    check("b2b_beats", beats - b0, 2);

    b0 = beats;
    send_word(32'd0, waited);
    check("zero_accept_wait", waited, 0);
    repeat (3) @(posedge clk);
    #1 check("zero_beats", beats - b0, 0);

    b0 = beats;
    send_word(32'hFFFF_FFFF, waited);
    wait_idle();
    check("ones_beats", beats - b0, 32);

    rnd_rdy = 1'b1;
    b0 = beats;
    send_word(32'd43758, waited);
    wait_idle();
    check("stall_beats", beats - b0, 10);
    rnd_rdy = 1'b0;

    send_word(32'd43758, waited);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.out_valid_o && bus.out_ready_i && bus.out_index_o == 5'd3) break;
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", bus.out_valid_o, 0);
    check("midrst_ready", bus.in_ready_o, 1);
    @(posedge clk); #1;
    b0 = beats;
    send_word(32'd4096, waited);
    wait_idle();
    check("midrst_after_beats", beats - b0, 1);

    rnd_rdy = 1'b1;
    for (int k = 0; k < 25; k++) begin
      logic [W-1:0] w;
      int exp_n;
      w = W'($urandom);
      if (k % 3 == 0) w = w & W'($urandom) & W'($urandom);
      if (k == 7) w = 32'h8000_0000;
      if (k == 8) w = 32'h0000_0001;
      exp_n = $countones(w);
      b0 = beats;
      send_word(w, waited);
      wait_idle();
      check("rand_beats", beats - b0, exp_n);
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bit_index_scanner.md
Name: bit_index_scanner

Overview:
- Inverse of the shift-based `1 << pos` index-to-one-hot helper used across the codebase: takes a multi-hot bit vector and emits the index of every set bit, one index per handshake.
- Order is LSB-first by default.
- Sits between a producer of request/enable masks and consumers that need binary indices, for example arbiters and register-file writeback.
- Valid/ready stream on both sides; one word is processed at a time.

Parameters:
- Width, 32, width of the input bit vector (≥2).
- IdxWidth, $clog2(Width), width of the emitted index. Derived; not to be overridden.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, synchronous, active-high
- in_data_i  input  Width  bit vector to scan
- in_valid_i  input  1  input word valid
- in_ready_o  output  1  block can accept a word
- out_index_o  output  IdxWidth  index of the current set bit
- out_last_o  output  1  current index is the final set bit of the word
- out_valid_o  output  1  out_index_o/out_last_o valid
- out_ready_i  input  1  consumer accepts the index
- busy_o  output  1  a word is being scanned

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset values: in_ready_o=1, out_valid_o=0, out_index_o=0, out_last_o=0, busy_o=0. Internal mask register=0, state=IDLE.
- FSM states IDLE and SCAN.
- IDLE:
  - in_ready_o=1, out_valid_o=0.
  - On in_valid_i && in_ready_o with in_data_i≠0: latch mask←in_data_i, go to SCAN.
  - With in_data_i==0: word consumed, no output produced, stay in IDLE.
- SCAN:
  - in_ready_o=0, busy_o=1, out_valid_o=1.
  - out_index_o = position of the lowest set bit of mask (combinational from the registered mask).
  - out_last_o = 1 iff exactly one bit of mask is set.
- Output handshake (out_valid_o && out_ready_i): clear that bit in mask. If out_last_o was 1, go to IDLE.
- No input acceptance in the same cycle as the last output handshake; the next word is accepted one cycle later (in IDLE).
- Latency:
  - First index is valid the cycle after input acceptance.
  - A word with N set bits takes N output handshakes. Under full throughput the next word is accepted N+1 cycles after the previous acceptance.
- Backpressure: while out_ready_i=0, out_index_o, out_last_o and out_valid_o hold stable (AXI-style valid rule: valid never drops without a handshake).
- Width rules:
  - out_index_o ranges 0..Width-1 and is zero-extended to IdxWidth.
  - Bit Width-1 must be reported correctly (no overflow when Width is a power of two).
- Boundary cases:
  - All-ones word: Width indices 0..Width-1, last on Width-1.
  - Single-bit word: one beat with out_last_o=1.
- Reset mid-scan: in the next cycle the mask is cleared, state returns to IDLE, out_valid_o=0, and remaining indices are discarded.
- in_data_i is sampled only on an input handshake; changes while in SCAN have no effect.

Optional Feature:
- Macro: BIT_INDEX_SCANNER_MSB_FIRST_EN.
- Defined: scan order is MSB-first. out_index_o is the highest set bit of mask, and out_last_o marks the lowest set bit. All other behaviour, latency and reset values are unchanged.
- Undefined: LSB-first as specified above.

Test Plan:
- Width=32, send 32'd43758 (0xAAEE), out_ready_i=1 → indices 1,2,3,5,6,7,9,11,13,15 on 10 consecutive cycles starting one cycle after acceptance; out_last_o only with 15; in_ready_o high again the cycle after index 15. With the MSB_FIRST macro: 15,13,11,9,7,6,5,3,2,1, last on 1.
- Send 32'd32, then 32'd4096 back-to-back with in_valid_i held high → index 5 (last=1), then index 12 (last=1); second word accepted exactly one cycle after the index-5 handshake.
- Send 32'd0 → accepted in one cycle, out_valid_o stays 0, in_ready_o never drops.
- Send 32'hFFFF_FFFF → 32 beats 0..31, last with 31, out_index_o=31 with no wrap.
- Send 32'd43758 and toggle out_ready_i 0/1 randomly → identical index sequence; outputs stable while stalled; no beats lost or duplicated.
- Send 32'd43758 and assert rst_i for one cycle after index 3 is consumed → next cycle out_valid_o=0, in_ready_o=1; a following 32'd4096 yields only index 12.
